// File: rtl/vote_sequencer.sv
// vote_sequencer: collects one vote from each of three voters per round and reports majority, unanimity and the lone dissenter.
// Optional COLLECT watchdog compiled in with `define VOTE_SEQUENCER_TIMEOUT_EN.
module vote_sequencer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] vote_valid,
    input  logic [2:0] vote_bit,
    output logic       busy,
    output logic       result,
    output logic       result_valid,
    output logic       unanimous,
    output logic [1:0] dissent_id,
    output logic       timeout
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t     state_q, state_d;
    logic [2:0] mask_q, mask_d, votes_q, votes_d;
    logic       result_q, result_d, unan_q, unan_d, timeout_q, timeout_d;
    logic [1:0] dissent_q, dissent_d;
    logic [2:0] new_mask, new_votes;
    logic       full, expire, maj, same;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..255");
    end

`ifdef VOTE_SEQUENCER_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    // watchdog counts COLLECT cycles; zero in every other state so it restarts on entry
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign cnt_d  = (state_q == COLLECT) ? cnt_q + 8'd1 : 8'd0;
    assign expire = (cnt_q == 8'(TIMEOUT_CYCLES - 1)) && !full;
`else
    assign expire = 1'b0;
`endif

    // votes already captured take priority; missing votes stay 0 when the round times out
    assign new_mask  = mask_q | vote_valid;
    assign new_votes = votes_q | (vote_valid & ~mask_q & vote_bit);
    assign full      = &new_mask;
    assign maj       = (new_votes[0] & new_votes[1]) | (new_votes[1] & new_votes[2]) | (new_votes[0] & new_votes[2]);
    assign same      = (new_votes == 3'b000) || (new_votes == 3'b111);

    // state, capture and result registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            votes_q   <= '0;
            result_q  <= 1'b0;
            unan_q    <= 1'b0;
            dissent_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            votes_q   <= votes_d;
            result_q  <= result_d;
            unan_q    <= unan_d;
            dissent_q <= dissent_d;
            timeout_q <= timeout_d;
        end

    // next state: start opens a round, captures accumulate in COLLECT, results latch on the closing edge
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        votes_d   = votes_q;
        result_d  = result_q;
        unan_d    = unan_q;
        dissent_d = dissent_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: if (start) begin
                state_d   = COLLECT;
                mask_d    = '0;
                votes_d   = '0;
                result_d  = 1'b0;
                unan_d    = 1'b0;
                dissent_d = '0;
                timeout_d = 1'b0;
            end
            COLLECT: begin
                mask_d  = new_mask;
                votes_d = new_votes;
                if (full || expire) begin
                    state_d   = DONE;
                    result_d  = maj;
                    unan_d    = same;
                    dissent_d = same ? 2'd0 : (new_votes[0] != maj) ? 2'd1 : (new_votes[1] != maj) ? 2'd2 : 2'd3;
                    timeout_d = expire;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy         = state_q != IDLE;
    assign result_valid = state_q == DONE;
    assign result       = result_q;
    assign unanimous    = unan_q;
    assign dissent_id   = dissent_q;
    assign timeout      = timeout_q;
endmodule
